// File: rtl/aes_enc_core.sv
// aes_enc_core: iterative AES-128 encryption datapath sharing an external S-box one word per cycle
module aes_enc_core #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         init,
  input  logic [127:0] plaintext,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  input  logic         key_ready,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw,
  output logic [127:0] ciphertext,
  output logic         ready
);
  typedef enum logic [2:0] {IDLE, INIT, SBOX, MAIN, DONE} state_t;
  state_t state, state_nxt;
  logic [127:0] block;
  logic [3:0] round_ctr;
  logic [1:0] sbox_ctr;
  logic last;
  logic [6:0] word_lsb;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  // Row r of column c comes from column c+r
  function automatic logic [127:0] shift_rows(input logic [127:0] b);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-32*c-8*r -: 8] = b[127-32*((c+r)%4)-8*r -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] b);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      o[127-32*c -: 32] = mix_col(b[127-32*c -: 32]);
    return o;
  endfunction

  assign last = round_ctr == 4'(NR);
  assign word_lsb = {~sbox_ctr, 5'd0};

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;

  always_comb begin
    state_nxt = state == IDLE ? (init ? INIT : IDLE) :
                state == INIT ? (key_ready ? SBOX : INIT) :
                state == SBOX ? (sbox_ctr == 2'd3 ? MAIN : SBOX) :
                state == MAIN ? (key_ready ? (last ? DONE : SBOX) : MAIN) :
                IDLE;
  end

  always_comb begin
    sboxw = state == SBOX ? block[word_lsb +: 32] : 32'h0;
    round = round_ctr;
    ciphertext = block;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      block <= '0;
      round_ctr <= '0;
      sbox_ctr <= '0;
      ready <= 1'b1;
    end else begin
      case (state)
        IDLE: if (init) begin
          round_ctr <= '0;
          ready <= 1'b0;
        end
        INIT: if (key_ready) begin
          block <= plaintext ^ round_key;
          round_ctr <= 4'd1;
          sbox_ctr <= '0;
        end
        SBOX: begin
          block[word_lsb +: 32] <= new_sboxw;
          sbox_ctr <= sbox_ctr + 2'd1;
        end
        MAIN: if (key_ready) begin
          if (last) begin
            block <= shift_rows(block) ^ round_key;
            ready <= 1'b1;
          end else begin
            block <= mix_columns(shift_rows(block)) ^ round_key;
            round_ctr <= round_ctr + 4'd1;
          end
        end
        default: ;
      endcase
    end
endmodule
